// File: rtl/fp_alu_pkg.sv
// Shared constants for the single-precision add/multiply pipeline.
// The opcode values are the encoding of the per-operation select bit.
package fp_alu_pkg;

  localparam int unsigned FP_BIAS        = 127;
  localparam logic [7:0]  FP_EXP_MAX     = 8'hFF;
  localparam int unsigned FP_EXP_W       = 8;
  localparam int unsigned FP_FRAC_W      = 23;
  localparam int unsigned FP_ALU_LATENCY = 29;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/fp_alu_core.sv
// Combinational single-precision add/multiply with truncation, denormal flush-to-zero and
// saturation of specials/overflow to a signed {FF, 0} pattern.
module fp_alu_core import fp_alu_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] r,
  output logic        exception
);

  logic                 w_sa, w_sb;
  logic [FP_EXP_W-1:0]  w_ea, w_eb;
  logic [FP_FRAC_W:0]   w_ma, w_mb;
  logic                 w_special;

  assign w_sa      = a[31];
  assign w_sb      = b[31];
  assign w_ea      = a[30:23];
  assign w_eb      = b[30:23];
  assign w_ma      = (w_ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
  assign w_mb      = (w_eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
  assign w_special = (w_ea == FP_EXP_MAX) || (w_eb == FP_EXP_MAX);

  // Add path: larger magnitude first, align, add/subtract, renormalise.
  logic        w_swap, w_sl, w_ss;
  logic [7:0]  w_el, w_es, w_diff;
  logic [23:0] w_ml, w_ms, w_msh, w_norm;
  logic [24:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_add_exp;
  logic [22:0] w_add_frac;

  assign w_swap = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_sl   = w_swap ? w_sb : w_sa;
  assign w_ss   = w_swap ? w_sa : w_sb;
  assign w_el   = w_swap ? w_eb : w_ea;
  assign w_es   = w_swap ? w_ea : w_eb;
  assign w_ml   = w_swap ? w_mb : w_ma;
  assign w_ms   = w_swap ? w_ma : w_mb;
  assign w_diff = w_el - w_es;
  assign w_msh  = (w_diff >= 8'd25) ? 24'd0 : (w_ms >> w_diff);
  assign w_sum  = (w_sl == w_ss) ? ({1'b0, w_ml} + {1'b0, w_msh})
                                 : ({1'b0, w_ml} - {1'b0, w_msh});

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (w_sum[i]) w_lz = 5'(23 - i);
    end
  end

  assign w_norm     = w_sum[23:0] << w_lz;
  assign w_add_exp  = w_sum[24] ? ({2'b00, w_el} + 10'd1) : ({2'b00, w_el} - {5'd0, w_lz});
  assign w_add_frac = w_sum[24] ? w_sum[23:1] : w_norm[22:0];

  // Multiply path: product of two [1,2) significands lies in [1,4).
  logic [47:0] w_prod;
  logic [9:0]  w_mul_exp;
  logic [22:0] w_mul_frac;

  assign w_prod     = {24'd0, w_ma} * {24'd0, w_mb};
  assign w_mul_exp  = {2'b00, w_ea} + {2'b00, w_eb} - 10'(FP_BIAS) + {9'd0, w_prod[47]};
  assign w_mul_frac = w_prod[47] ? w_prod[46:24] : w_prod[45:23];

  logic w_unused;
  assign w_unused = ^{w_norm[23], w_prod[22:0]};

  logic        w_sign, w_zero;
  logic [9:0]  w_exp;
  logic [22:0] w_frac;

  always_comb begin
    w_sign = w_sl;
    w_exp  = w_add_exp;
    w_frac = w_add_frac;
    w_zero = (w_sum == 25'd0);
    if (s == OP_MUL) begin
      w_sign = w_sa ^ w_sb;
      w_exp  = w_mul_exp;
      w_frac = w_mul_frac;
      w_zero = (w_ea == 8'd0) || (w_eb == 8'd0);
    end

    exception = 1'b0;
    r         = {w_sign, w_exp[7:0], w_frac};
    if (w_special) begin
      exception = 1'b1;
      r         = {w_sign, FP_EXP_MAX, 23'd0};
    end else if (w_zero) begin
      // Exact cancellation in the adder is always +0; a zero factor keeps its sign.
      r = (s == OP_MUL) ? {w_sign, 31'd0} : 32'd0;
    end else if ($signed(w_exp) >= 10'sd255) begin
      exception = 1'b1;
      r         = {w_sign, FP_EXP_MAX, 23'd0};
    end else if ($signed(w_exp) <= 10'sd0) begin
      r = {w_sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_alu.sv
// Streaming FP add/multiply: operands registered, combinational core, then a clearable
// delay line so every result appears LATENCY-1 edges after its capture edge.
module fp_alu import fp_alu_pkg::*; #(
  parameter int unsigned LATENCY = FP_ALU_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] r,
  output logic        exception
);

  logic [32:0] w_out;

  if (LATENCY <= 1) begin : g_single
    logic [31:0] w_r;
    logic        w_exc;
    logic [32:0] r_out;

    fp_alu_core u_core (
      .a         (a),
      .b         (b),
      .s         (s),
      .r         (w_r),
      .exception (w_exc)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_out <= '0;
      else        r_out <= {w_exc, w_r};
    end

    assign w_out = r_out;
  end else begin : g_pipe
    logic [31:0] r_a, r_b;
    logic        r_s;
    logic [31:0] w_r;
    logic        w_exc;
    logic [32:0] r_pipe [LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_a <= '0;
        r_b <= '0;
        r_s <= 1'b0;
      end else begin
        r_a <= a;
        r_b <= b;
        r_s <= s;
      end
    end

    fp_alu_core u_core (
      .a         (r_a),
      .b         (r_b),
      .s         (r_s),
      .r         (w_r),
      .exception (w_exc)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= {w_exc, w_r};
        for (int unsigned i = 1; i < LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_out = r_pipe[LATENCY-2];
  end

  assign exception = w_out[32];
  assign r         = w_out[31:0];

endmodule

// File: tb/tb_fp_alu.sv
// Directed-vector and interleaved-stream bench for fp_alu, checking every output cycle
// against an expectation keyed by the edge at which it must appear.
module tb_fp_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        s;
  logic [31:0] r;
  logic        exception;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] exp_at  [int];
  string       name_at [int];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vecs [16];

  fp_alu dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .s         (s),
    .r         (r),
    .exception (exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [32:0] got, input logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got r=%h exc=%b, expected r=%h exc=%b",
               nm, cyc, got[31:0], got[32], want[31:0], want[32]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_at.exists(cyc)) begin
      check(name_at[cyc], {exception, r}, exp_at[cyc]);
      exp_at.delete(cyc);
      name_at.delete(cyc);
    end
  end

  // Independent golden model: integer arithmetic with iterative normalisation.
  function automatic logic [32:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                        input logic fs);
    int          ea, eb, el, es, e, d;
    longint      ma, mb, ml, ms, m;
    logic        sg, sl, ss;
    logic [22:0] frac;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    ma = 0;
    mb = 0;
    if (ea != 0) ma = longint'(fa[22:0]) + 64'h80_0000;
    if (eb != 0) mb = longint'(fb[22:0]) + 64'h80_0000;
    if (fs) begin
      sg = fa[31] ^ fb[31];
      if (ea == 255 || eb == 255) return {1'b1, sg, 8'hFF, 23'd0};
      if (ma == 0 || mb == 0) return {1'b0, sg, 31'd0};
      m = ma * mb;
      e = ea + eb - 127;
      if (m >= (64'd1 << 47)) begin
        m = m >> 1;
        e++;
      end
      frac = m[45:23];
    end else begin
      if ((eb > ea) || (eb == ea && mb > ma)) begin
        sl = fb[31]; ss = fa[31]; el = eb; es = ea; ml = mb; ms = ma;
      end else begin
        sl = fa[31]; ss = fb[31]; el = ea; es = eb; ml = ma; ms = mb;
      end
      sg = sl;
      if (ea == 255 || eb == 255) return {1'b1, sg, 8'hFF, 23'd0};
      d = el - es;
      if (d >= 25) ms = 0;
      else         ms = ms >> d;
      m = (sl == ss) ? ml + ms : ml - ms;
      if (m == 0) return 33'd0;
      e = el;
      while (m >= (64'd1 << 24)) begin m = m >> 1; e++; end
      while (m <  (64'd1 << 23)) begin m = m << 1; e--; end
      frac = m[22:0];
    end
    if (e >= 255) return {1'b1, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, sg, 31'd0};
    return {1'b0, sg, 8'(e), frac};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [31:0] f;
    e = 8'($urandom_range(100, 154));
    f = $urandom;
    return {f[31], e, f[22:0]};
  endfunction

  // Operands set after negedge at cycle k are captured at edge k+1 and appear at edge k+29.
  task automatic drive(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                       input logic [32:0] want, input string nm);
    @(negedge clk);
    a = oa;
    b = ob;
    s = os;
    exp_at[cyc + 29]  = want;
    name_at[cyc + 29] = nm;
  endtask

  initial begin
    logic [31:0] ra, rb;
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, "add_1_1"};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, "add_cancel"};
    vecs[2]  = '{32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 1'b0, "mul_2_3"};
    vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 1'b0, "mul_1p5_1p5"};
    vecs[4]  = '{32'h00000000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, "mul_zero"};
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, "add_trunc"};
    vecs[6]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h407FFFFE, 1'b0, "mul_trunc"};
    vecs[7]  = '{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 1'b1, "mul_overflow"};
    vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, "add_inf"};
    vecs[9]  = '{32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, "mul_underflow"};
    vecs[10] = '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, "add_3_m1"};
    vecs[11] = '{32'hBF800000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, "mul_m1_2"};
    vecs[12] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, "add_m2_1"};
    vecs[13] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, "add_overflow"};
    vecs[14] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, "add_denorm"};
    vecs[15] = '{32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 1'b0, "mul_neg_zero"};

    reset = 1'b0;
    a = '0;
    b = '0;
    s = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {exception, r}, 33'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      exp_at[cyc + k]  = 33'd0;
      name_at[cyc + k] = "idle_after_reset";
    end

    foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].exc, vecs[i].r}, vecs[i].name);

    for (int i = 0; i < 24; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      drive(ra, rb, 1'(i), model(ra, rb, 1'(i)), "interleave");
    end
    repeat (30) drive(32'd0, 32'd0, 1'b0, 33'd0, "drain");

    // Fill the pipeline so outputs are live, then drop reset with ops still in flight.
    for (int i = 0; i < 40; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      drive(ra, rb, 1'(i), model(ra, rb, 1'(i)), "prefill");
    end
    #2;
    reset = 1'b0;
    exp_at.delete();
    name_at.delete();
    #1;
    check("reset_async_clear", {exception, r}, 33'd0);
    repeat (3) @(negedge clk);
    check("reset_held", {exception, r}, 33'd0);
    a = '0;
    b = '0;
    s = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      exp_at[cyc + k]  = 33'd0;
      name_at[cyc + k] = "stay_zero_after_release";
    end
    repeat (3) drive(32'd0, 32'd0, 1'b0, 33'd0, "idle_post_release");
    drive(32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 32'h40000000}, "first_after_release");
    drive(32'h40000000, 32'h40400000, 1'b1, {1'b0, 32'h40C00000}, "second_after_release");
    repeat (30) drive(32'd0, 32'd0, 1'b0, 33'd0, "final_drain");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
